// File: rtl/adder_tree_pkg.sv
// Shared types and defaults for the adder-tree accumulator controller.
// sat_add is only referenced when ADDER_TREE_ACC_SAT_EN is defined.
package adder_tree_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} acc_state_e;

  localparam int ADT_N     = 12;
  localparam int ADT_K     = 15;
  localparam int ADT_ACC_W = 24;
  localparam int ADT_LEN_W = 8;

  // Operands arrive sign-extended to 64 bits; result is clamped to a w-bit signed range.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned w);
    logic signed [63:0] s, hi, lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi)      sat_add = hi;
    else if (s < lo) sat_add = lo;
    else             sat_add = s;
  endfunction

endpackage

// File: rtl/adder_tree_acc_ctrl_tree.sv
// Combinational N-lane reduction; the K-bit sum wraps modulo 2^K.
module adder_tree #(
  parameter int N = 12,
  parameter int K = 15
) (
  input  logic [K-1:0] in_data [0:N-1],
  output logic [K-1:0] sum
);

  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) sum = sum + in_data[i];
  end

endmodule

// File: rtl/adder_tree_acc_ctrl.sv
// Sequencer/accumulator around adder_tree: sums cfg_len reduced beats per job.
// Define ADDER_TREE_ACC_SAT_EN to saturate instead of wrap on overflow.
module adder_tree_acc_ctrl
  import adder_tree_pkg::*;
#(
  parameter int N     = ADT_N,
  parameter int K     = ADT_K,
  parameter int ACC_W = ADT_ACC_W,
  parameter int LEN_W = ADT_LEN_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LEN_W-1:0]        cfg_len,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [K-1:0]            in_data [0:N-1],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum,
  output logic                    out_ovf,
  output logic                    busy
);

  acc_state_e              state;
  logic signed [ACC_W-1:0] acc, tree_ext, sum_w, acc_add;
  logic [K-1:0]            tree_sum;
  logic [LEN_W-1:0]        cnt, len_q, len_eff, cnt_inc;
  logic                    ovf, ovf_w, accept;

  adder_tree #(.N(N), .K(K)) u_tree (
    .in_data (in_data),
    .sum     (tree_sum)
  );

  assign tree_ext = ACC_W'(signed'(tree_sum));
  assign sum_w    = acc + tree_ext;
  assign ovf_w    = (acc[ACC_W-1] == tree_ext[ACC_W-1]) && (sum_w[ACC_W-1] != acc[ACC_W-1]);

`ifdef ADDER_TREE_ACC_SAT_EN
  assign acc_add = ACC_W'(sat_add(64'(acc), 64'(tree_ext), ACC_W));
`else
  assign acc_add = sum_w;
`endif

  assign len_eff = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
  assign cnt_inc = cnt + LEN_W'(1);

  // HOLD only takes a new beat when the pending result leaves in the same cycle.
  always_comb begin
    in_ready = 1'b0;
    if (!flush) in_ready = (state == HOLD) ? out_ready : 1'b1;
  end

  assign accept  = in_valid & in_ready;
  assign busy    = (state != IDLE);
  assign out_sum = acc;
  assign out_ovf = ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      acc       <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
      len_q     <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            len_q     <= len_eff;
            acc       <= tree_ext;
            cnt       <= LEN_W'(1);
            ovf       <= 1'b0;
            state     <= (len_eff == LEN_W'(1)) ? HOLD : ACCUM;
            out_valid <= (len_eff == LEN_W'(1));
          end else if (state == HOLD && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc <= acc_add;
            cnt <= cnt_inc;
            ovf <= ovf | ovf_w;
            if (cnt_inc == len_q) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_tree_acc_ctrl.sv
// Scoreboard bench for adder_tree_acc_ctrl built with ACC_W=16 so overflow is reachable.
// Expected results follow ADDER_TREE_ACC_SAT_EN the same way the design does.
module tb_adder_tree_acc_ctrl;

  localparam int N = 12, K = 15, ACC_W = 16, LEN_W = 8;
  localparam int AMAX = 32767, AMIN = -32768;

  typedef struct {
    int sum;
    bit ovf;
  } exp_t;

  logic                    clk = 1'b0, rst_n = 1'b0;
  logic [LEN_W-1:0]        cfg_len = '0;
  logic                    flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic                    in_ready, out_valid, out_ovf, busy;
  logic [K-1:0]            in_data [0:N-1];
  logic signed [ACC_W-1:0] out_sum;

  exp_t q[$];
  int   n_chk = 0, n_err = 0, cyc = 0;
  int   m_cnt = 0, m_len = 0, m_acc = 0;
  bit   m_ovf = 0;

  adder_tree_acc_ctrl #(.N(N), .K(K), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", tag, act, exp);
    end
  endtask

  // Reference model of one accepted beat.
  task automatic model_accept(input int l0, input int lr, input int len);
    logic signed [K-1:0]     tw;
    logic signed [ACC_W-1:0] ww;
    int t, s;
    bit o;
    tw = K'(l0 + (N - 1) * lr);
    t  = int'(tw);
    if (m_cnt == 0) begin
      m_len = (len == 0) ? 1 : len;
      m_acc = t;
      m_ovf = 0;
      m_cnt = 1;
    end else begin
      s = m_acc + t;
      o = (s > AMAX) || (s < AMIN);
`ifdef ADDER_TREE_ACC_SAT_EN
      m_acc = (s > AMAX) ? AMAX : (s < AMIN) ? AMIN : s;
`else
      ww    = ACC_W'(s);
      m_acc = int'(ww);
`endif
      m_ovf = m_ovf | o;
      m_cnt++;
    end
    if (m_cnt == m_len) begin
      q.push_back('{sum: m_acc, ovf: m_ovf});
      m_cnt = 0;
    end
  endtask

  // Present lane 0 = l0, lanes 1..N-1 = lr; returns #1 after the accepting edge.
  task automatic beat(input int l0, input int lr, input int len);
    bit ok = 0;
    in_data[0] = K'(l0);
    for (int i = 1; i < N; i++) in_data[i] = K'(lr);
    cfg_len  = LEN_W'(len);
    in_valid = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = in_ready;
      if (ok) model_accept(l0, lr, len);
      @(posedge clk); #1;
    end
    if (!ok) chk("beat_accept", in_ready, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      if (q.size() == 0) chk("spurious_out", out_valid, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("out_sum", out_sum, e.sum);
        chk("out_ovf", out_ovf, e.ovf);
      end
    end
  end

  initial begin
    int c0;
    for (int i = 0; i < N; i++) in_data[i] = '0;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_ovf", out_ovf, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("idle_ready", in_ready, 1);

    // len=4, all lanes 1: 48, valid exactly one cycle after the 4th beat
    for (int b = 0; b < 4; b++) begin
      beat(1, 1, 4);
      if (b == 2) chk("lat_early", out_valid, 0);
    end
    chk("lat_valid", out_valid, 1);
    idle(2);
    chk("idle_after", busy, 0);

    // sign extension: -24 + 60 - 12 = 24
    beat(-2, -2, 3); beat(5, 5, 3); beat(-1, -1, 3);
    idle(2);

    // backpressure in HOLD, then overlapped release
    out_ready = 1'b0;
    beat(3, 3, 2); beat(3, 3, 2);
    in_data[0] = K'(7);
    for (int i = 1; i < N; i++) in_data[i] = K'(-1);
    cfg_len = 8'd1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_sum", out_sum, 72);
      chk("bp_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    beat(7, -1, 1);
    idle(2);

    // cfg_len 0 / 1 stream: one beat and one result per cycle
    c0 = cyc;
    for (int b = 0; b < 6; b++)
      beat(int'($urandom_range(0, 32767)), int'($urandom_range(0, 32767)), b % 2);
    chk("len1_thru", cyc - c0, 6);
    idle(2);

    // flush after 2 of 4 beats, beat in flush cycle dropped
    beat(1, 2, 4); beat(1, 2, 4);
    flush = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("flush_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    m_cnt = 0;
    chk("flush_busy", busy, 0);
    chk("flush_valid", out_valid, 0);
    idle(3);
    beat(2, 1, 2); beat(2, 1, 2);
    idle(2);

    // overflow: 3 x 16383 exceeds 16-bit range
    for (int b = 0; b < 3; b++) beat(16383, 0, 3);
    idle(2);
    // overflow then a large negative beat (recovers in range when saturating)
    for (int b = 0; b < 3; b++) beat(16383, 0, 4);
    beat(-16384, 0, 4);
    idle(2);

    // async reset mid-ACCUM
    beat(1, 1, 4); beat(1, 1, 4);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_sum", out_sum, 0);
    chk("arst_ovf", out_ovf, 0);
    chk("arst_busy", busy, 0);
    m_cnt = 0;
    q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    idle(3);
    beat(4, 0, 1);
    idle(3);
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
